// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point radix-2 FFT datapath and its frame
// controller: frame geometry, controller state encoding, the 4-bit
// bit-reversal helper and the twiddle factors W16^k = exp(-j*2*pi*k/16)
// in signed 16.16 fixed point, used by fft_stage1..fft_stage4.
package fft_pkg;

    localparam int FFT_N     = 16;
    localparam int FFT_LOG2N = 4;
    localparam int FFT_DW    = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CAPT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    localparam logic signed [31:0] W0_RE =  32'sd65536;
    localparam logic signed [31:0] W0_IM =  32'sd0;
    localparam logic signed [31:0] W1_RE =  32'sd60547;
    localparam logic signed [31:0] W1_IM = -32'sd25080;
    localparam logic signed [31:0] W2_RE =  32'sd46341;
    localparam logic signed [31:0] W2_IM = -32'sd46341;
    localparam logic signed [31:0] W3_RE =  32'sd25080;
    localparam logic signed [31:0] W3_IM = -32'sd60547;
    localparam logic signed [31:0] W4_RE =  32'sd0;
    localparam logic signed [31:0] W4_IM = -32'sd65536;
    localparam logic signed [31:0] W5_RE = -32'sd25080;
    localparam logic signed [31:0] W5_IM = -32'sd60547;
    localparam logic signed [31:0] W6_RE = -32'sd46341;
    localparam logic signed [31:0] W6_IM = -32'sd46341;
    localparam logic signed [31:0] W7_RE = -32'sd60547;
    localparam logic signed [31:0] W7_IM = -32'sd25080;

endpackage

// File: rtl/fft16_frame_ctrl_if.sv
// Sample stream interface for fft16_frame_ctrl.
//   in_valid/in_data/in_ready    : serial input samples into the controller
//   out_valid/out_data/out_ready : serial result samples out of the controller
// slave  : the controller side (consumes input stream, produces output stream)
// master : the environment side (produces input stream, consumes output stream)
interface fft16_frame_ctrl_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer for the 16-point FFT datapath. Collects 16 serial samples
// into a frame buffer, steps the four stage registers one per cycle, captures
// the stage-4 result and streams it out (optionally un-bit-reversed).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   en           : permits a new frame to start (from IDLE or at end of DRAIN)
//   s_if         : input/output sample streams (valid/ready)
//   fft_bus_out  : frame buffer to stage 1, word i at [DW*i +: DW]
//   stage_en     : one-hot load enable of stage-k output register (bit k-1)
//   fft_bus_in   : stage-4 output bus, same packing
//   busy         : high whenever not IDLE
//   frame_done   : one-cycle pulse after the 16th output handshake
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | waiting for en
// ST_LOAD  | accepting 16 input samples into the frame buffer
// ST_RUN   | pulsing stage_en[0..3], one stage per cycle
// ST_CAPT  | latching the stage-4 bus into the result buffer
// ST_DRAIN | streaming 16 results out under valid/ready
module fft16_frame_ctrl
    import fft_pkg::*;
#(
    parameter int DW         = FFT_DW,
    parameter int N          = FFT_N,
    parameter int BITREV_OUT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    fft16_frame_ctrl_if.slave   s_if,
    output logic [N*DW-1:0]     fft_bus_out,
    output logic [3:0]          stage_en,
    input  logic [N*DW-1:0]     fft_bus_in,
    output logic                busy,
    output logic                frame_done
);

    state_t                 state_q, state_d;
    logic [FFT_LOG2N-1:0]   wr_cnt_q, wr_cnt_d;
    logic [1:0]             stg_cnt_q, stg_cnt_d;
    logic [FFT_LOG2N-1:0]   rd_cnt_q, rd_cnt_d;
    logic                   frame_done_q, frame_done_d;
    logic [DW-1:0]          frame_q [N];
    logic [DW-1:0]          frame_d [N];
    logic [DW-1:0]          res_q   [N];
    logic [DW-1:0]          res_d   [N];
    logic [FFT_LOG2N-1:0]   rd_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= '0;
            stg_cnt_q    <= '0;
            rd_cnt_q     <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                frame_q[i] <= '0;
                res_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            stg_cnt_q    <= stg_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            frame_done_q <= frame_done_d;
            frame_q      <= frame_d;
            res_q        <= res_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        stg_cnt_d    = stg_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        frame_done_d = 1'b0;
        frame_d      = frame_q;
        res_d        = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // in_ready is high for the whole state, so in_valid alone is the accept
                if (s_if.in_valid) begin
                    frame_d[wr_cnt_q] = s_if.in_data;
                    wr_cnt_d          = wr_cnt_q + 4'd1;
                    if (wr_cnt_q == 4'd15) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                stg_cnt_d = stg_cnt_q + 2'd1;
                if (stg_cnt_q == 2'd3) state_d = ST_CAPT;
            end
            ST_CAPT: begin
                for (int i = 0; i < N; i++) begin
                    res_d[i] = fft_bus_in[DW*i +: DW];
                end
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (s_if.out_ready) begin
                    rd_cnt_d = rd_cnt_q + 4'd1;
                    if (rd_cnt_q == 4'd15) begin
                        frame_done_d = 1'b1;
                        state_d      = en ? ST_LOAD : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage 4 leaves results in bit-reversed order; undo it on the read side.
    assign rd_idx = (BITREV_OUT != 0) ? bitrev4(rd_cnt_q) : rd_cnt_q;

    always_comb begin
        fft_bus_out = '0;
        for (int i = 0; i < N; i++) begin
            fft_bus_out[DW*i +: DW] = frame_q[i];
        end
    end

    assign s_if.in_ready  = (state_q == ST_LOAD);
    assign s_if.out_valid = (state_q == ST_DRAIN);
    assign s_if.out_data  = res_q[rd_idx];
    assign stage_en       = (state_q == ST_RUN) ? (4'b0001 << stg_cnt_q) : 4'b0000;
    assign busy           = (state_q != ST_IDLE);
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
module tb_fft16_frame_ctrl;

    localparam int DW = 32;
    localparam int N  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            out_ready = 1'b0;
    logic [N*DW-1:0] fft_bus_in;

    logic [N*DW-1:0] bus_out_a, bus_out_b;
    logic [3:0]      stage_en_a, stage_en_b;
    logic            busy_a, busy_b, done_a, done_b;

    int n_chk  = 0;
    int n_fail = 0;

    int exp_rev [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    fft16_frame_ctrl_if #(.DW(DW)) if_a ();
    fft16_frame_ctrl_if #(.DW(DW)) if_b ();

    assign if_a.in_valid  = in_valid;
    assign if_a.in_data   = in_data;
    assign if_a.out_ready = out_ready;
    assign if_b.in_valid  = in_valid;
    assign if_b.in_data   = in_data;
    assign if_b.out_ready = out_ready;

    fft16_frame_ctrl #(.DW(DW), .N(N), .BITREV_OUT(1)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .s_if       (if_a.slave),
        .fft_bus_out(bus_out_a),
        .stage_en   (stage_en_a),
        .fft_bus_in (fft_bus_in),
        .busy       (busy_a),
        .frame_done (done_a)
    );

    fft16_frame_ctrl #(.DW(DW), .N(N), .BITREV_OUT(0)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .s_if       (if_b.slave),
        .fft_bus_out(bus_out_b),
        .stage_en   (stage_en_b),
        .fft_bus_in (fft_bus_in),
        .busy       (busy_b),
        .frame_done (done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads samples i<<16, optionally pausing gap_len cycles after sample gap_after,
    // then follows the RUN/CAPT sequence and returns in the first DRAIN cycle.
    task automatic load_frame(input int gap_after, input int gap_len, input bit from_idle);
        if (from_idle) begin
            en = 1'b1;
            tick();
        end
        n_chk++;
        if (if_a.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_in_ready: got %b expected 1", if_a.in_ready);
        end
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i) << 16;
            tick();
            if (i == gap_after) begin
                in_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    n_chk++;
                    if (if_a.in_ready !== 1'b1 || stage_en_a !== 4'b0000) begin
                        n_fail++;
                        $display("FAIL gap_stall: in_ready %b stage_en %b expected 1 0000",
                                 if_a.in_ready, stage_en_a);
                    end
                    tick();
                end
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
        for (int s = 0; s < 4; s++) begin
            n_chk++;
            if (stage_en_a !== (4'b0001 << s) || if_a.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stage_en_T%0d: got %b in_ready %b expected %b 0",
                         s + 1, stage_en_a, if_a.in_ready, 4'b0001 << s);
            end
            tick();
        end
        n_chk++;
        if (stage_en_a !== 4'b0000 || if_a.out_valid !== 1'b0 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL capt_cycle: stage_en %b out_valid %b busy %b expected 0000 0 1",
                     stage_en_a, if_a.out_valid, busy_a);
        end
        for (int i = 0; i < 16; i++) begin
            n_chk++;
            if (bus_out_a[DW*i +: DW] !== (DW'(i) << 16)) begin
                n_fail++;
                $display("FAIL bus_out_word%0d: got %h expected %h",
                         i, bus_out_a[DW*i +: DW], DW'(i) << 16);
            end
        end
        tick();
        n_chk++;
        if (if_a.out_valid !== 1'b1 || if_b.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL out_valid_T6: got %b/%b expected 1", if_a.out_valid, if_b.out_valid);
        end
    endtask

    // Starts in the first DRAIN cycle; checks the ordered output of both DUTs.
    task automatic drain_check(input bit use_pat, input bit en_during);
        int k = 0;
        int cyc = 0;
        en = en_during;
        while (k < 16 && cyc < 200) begin
            out_ready = use_pat ? pat[cyc % 4] : 1'b1;
            n_chk++;
            if (if_a.out_valid !== 1'b1 || if_a.out_data !== DW'(exp_rev[k]) ||
                if_b.out_data !== DW'(k) || if_a.in_ready !== 1'b0 || done_a !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_k%0d: valid %b data_a %0d data_b %0d in_ready %b done %b expected 1 %0d %0d 0 0",
                         k, if_a.out_valid, if_a.out_data, if_b.out_data, if_a.in_ready, done_a,
                         exp_rev[k], k);
            end
            tick();
            if (out_ready) k++;
            cyc++;
        end
        out_ready = 1'b0;
        n_chk++;
        if (k != 16) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d handshakes expected 16", k);
        end
        n_chk++;
        if (if_a.out_valid !== 1'b0 || done_a !== 1'b1 || done_b !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_done: out_valid %b done %b/%b expected 0 1 1",
                     if_a.out_valid, done_a, done_b);
        end
        n_chk++;
        if (busy_a !== en_during || if_a.in_ready !== en_during) begin
            n_fail++;
            $display("FAIL after_drain: busy %b in_ready %b expected %b", busy_a, if_a.in_ready, en_during);
        end
        tick();
        n_chk++;
        if (done_a !== 1'b0 || done_b !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse_width: got %b/%b expected 0", done_a, done_b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_chk++;
        if (busy_a !== 1'b0 || if_a.in_ready !== 1'b0 || if_a.out_valid !== 1'b0 ||
            stage_en_a !== 4'b0000 || bus_out_a !== '0 || done_a !== 1'b0 || if_a.out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy %b in_ready %b out_valid %b stage_en %b done %b expected all 0",
                     busy_a, if_a.in_ready, if_a.out_valid, stage_en_a, done_a);
        end
        rst = 1'b0;
        en  = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        n_chk++;
        if (busy_a !== 1'b0 || if_a.in_ready !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: busy %b in_ready %b expected 0 0", busy_a, if_a.in_ready);
        end
    endtask

    task automatic test_load_and_bitrev();
        load_frame(-1, 0, 1'b1);
        drain_check(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        load_frame(-1, 0, 1'b1);
        en        = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        n_chk++;
        if (if_a.out_data !== DW'(exp_rev[3])) begin
            n_fail++;
            $display("FAIL pre_abort_data: got %0d expected %0d", if_a.out_data, exp_rev[3]);
        end
        rst = 1'b1;
        tick();
        out_ready = 1'b0;
        n_chk++;
        if (if_a.out_valid !== 1'b0 || busy_a !== 1'b0 || if_a.in_ready !== 1'b0 ||
            stage_en_a !== 4'b0000 || bus_out_a !== '0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: out_valid %b busy %b in_ready %b stage_en %b done %b expected all 0",
                     if_a.out_valid, busy_a, if_a.in_ready, stage_en_a, done_a);
        end
        rst = 1'b0;
        tick();
        tick();
        n_chk++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL post_abort_idle: busy %b done %b expected 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_backpressure();
        load_frame(-1, 0, 1'b1);
        drain_check(1'b1, 1'b0);
    endtask

    task automatic test_input_gaps();
        load_frame(7, 3, 1'b1);
        drain_check(1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        load_frame(-1, 0, 1'b0);
        drain_check(1'b0, 1'b0);
        for (int c = 0; c < 5; c++) tick();
        n_chk++;
        if (busy_a !== 1'b0 || if_a.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop_idle: busy %b in_ready %b expected 0 0", busy_a, if_a.in_ready);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) fft_bus_in[DW*i +: DW] = DW'(i);
        test_reset();
        test_load_and_bitrev();
        test_reset_mid_drain();
        test_backpressure();
        test_input_gaps();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
